// File: rtl/fifo_rd_stream.sv
// Read-domain output adapter for the async FIFO: pops words whenever the FIFO is
// non-empty and buffer space exists, and presents them on a registered FWFT stream.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  input  logic             flush,
  output logic [CNTW-1:0]  pop_count
);

  logic [DSIZE-1:0] b0;
  logic [DSIZE-1:0] b1;
  logic [1:0]       cnt;
  logic             accept;

  // The pop decision looks only at registered occupancy, so m_ready never
  // reaches rinc combinationally; the second slot absorbs the one-cycle lag.
  assign rinc    = ~rempty & ~flush & (cnt != 2'd2);
  assign m_valid = (cnt != 2'd0);
  assign m_data  = b0;
  assign accept  = m_valid & m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, which is what makes the pop/accept cases evaluate together.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      // NOTE: the two buffer slots are plain registers, so resetting them is
      // cheap and gives a defined m_data of zero out of reset.
      b0        <= '0;
      b1        <= '0;
      cnt       <= 2'd0;
      pop_count <= '0;
    end else begin
      if (rinc) pop_count <= pop_count + CNTW'(1);

      if (flush) begin
        // A same-cycle accept has already been taken by the consumer; the rest is dropped.
        cnt <= 2'd0;
      end else begin
        unique case ({rinc, accept})
          2'b10: begin
            if (cnt == 2'd0) b0 <= rdata;
            else             b1 <= rdata;
            cnt <= cnt + 2'd1;
          end
          2'b01: begin
            b0  <= b1;
            cnt <= cnt - 2'd1;
          end
          2'b11: b0 <= rdata;  // only reachable with one word held
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_rd_stream;

  logic       rclk;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       flush;
  logic [15:0] pop_count;

  logic       rinc_w;
  logic       m_valid_w;
  logic [7:0] m_data_w;
  logic [3:0] pop_count_w;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src[$];        // upstream FIFO contents
  logic [7:0] mq[$];         // model of the words held for the consumer
  logic [7:0] delivered[$];  // words the model saw accepted, in order
  int         mpop = 0;
  bit         env_pop = 0;

  fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .flush(flush),
    .pop_count(pop_count)
  );

  fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut_w (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc_w),
    .m_valid(m_valid_w), .m_data(m_data_w), .m_ready(m_ready), .flush(flush),
    .pop_count(pop_count_w)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO: registered empty flag, read data shows the head word.
  always @(posedge rclk) begin
    #1;
    if (env_pop && src.size() != 0) void'(src.pop_front());
    rempty = (src.size() == 0);
    rdata  = (src.size() != 0) ? src[0] : 8'h00;
  end

  // Compare process: check outputs against the model, then advance the model
  // by what the coming edge must do with the inputs now being presented.
  always @(negedge rclk) begin : compare
    bit exp_rinc;
    bit acc;
    if (!rrst_n) begin
      mq.delete();
      mpop = 0;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 8'h00);
      check("rst_pop_count", pop_count, 0);
      check("rst_rinc", rinc, 0);
      env_pop = 0;
    end else begin
      exp_rinc = !rempty && !flush && (mq.size() < 2);
      check("m_valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) check("m_data", m_data, mq[0]);
      check("rinc", rinc, exp_rinc);
      check("pop_count", pop_count, mpop % 65536);
      check("pop_count_w", pop_count_w, mpop % 16);
      check("m_valid_w", m_valid_w, mq.size() != 0);
      acc = (mq.size() != 0) && m_ready;
      if (acc) delivered.push_back(mq.pop_front());
      if (flush) mq.delete();
      else if (exp_rinc) mq.push_back(rdata);
      if (exp_rinc) mpop++;
      env_pop = rinc;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !m_valid; i++) cyc();
    check("wait_valid", m_valid, 1);
  endtask

  task automatic wait_delivered(input int n, input int budget);
    for (int i = 0; i < budget && delivered.size() < n; i++) cyc();
    check("wait_delivered", delivered.size(), n);
  endtask

  initial begin
    rrst_n  = 1'b0;
    rempty  = 1'b1;
    rdata   = 8'h00;
    m_ready = 1'b0;
    flush   = 1'b0;

    // Reset
    cyc(3);
    check("reset_valid", m_valid, 0);
    check("reset_data", m_data, 8'h00);
    check("reset_pop", pop_count, 0);
    check("reset_rinc", rinc, 0);
    rrst_n = 1'b1;
    cyc(3);
    check("post_reset_valid", m_valid, 0);
    check("post_reset_pop", pop_count, 0);
    check("post_reset_rinc", rinc, 0);

    // Single word with a stalled consumer
    src.push_back(8'hA5);
    wait_valid(10);
    check("single_data", m_data, 8'hA5);
    check("single_pop", pop_count, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("single_hold_valid", m_valid, 1);
      check("single_hold_data", m_data, 8'hA5);
      check("single_hold_rinc", rinc, 0);
    end
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    check("single_drained", m_valid, 0);
    check("single_delivered", delivered.size(), 1);
    check("single_word", delivered[0], 8'hA5);

    // Streaming at full rate; 17 pops total also wraps the 4-bit counter to 1
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    wait_delivered(17, 40);
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) check("stream_order", delivered[1 + i], i);
    check("stream_pop", pop_count, 17);
    check("wrap_pop_w", pop_count_w, 1);

    // Backpressure: exactly two pops, then random ready
    for (int i = 0; i < 8; i++) src.push_back(8'h30 + 8'(i));
    cyc(6);
    check("bp_pop", pop_count, 19);
    check("bp_rinc", rinc, 0);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 8'h30);
    for (int i = 0; i < 200 && delivered.size() < 25; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    m_ready = 1'b0;
    check("bp_delivered", delivered.size(), 25);
    for (int i = 0; i < 8; i++) check("bp_order", delivered[17 + i], 8'h30 + 8'(i));
    check("bp_pop_total", pop_count, 25);

    // Flush with a same-cycle accept
    src.push_back(8'h11);
    src.push_back(8'h22);
    src.push_back(8'h33);
    cyc(6);
    check("flush_pre_head", m_data, 8'h11);
    check("flush_pre_rinc", rinc, 0);
    check("flush_pre_pop", pop_count, 27);
    flush   = 1'b1;
    m_ready = 1'b1;
    cyc();
    flush   = 1'b0;
    m_ready = 1'b0;
    check("flush_valid", m_valid, 0);
    check("flush_no_pop", pop_count, 27);
    check("flush_count", delivered.size(), 26);
    check("flush_took", delivered[delivered.size() - 1], 8'h11);
    wait_valid(10);
    check("flush_next", m_data, 8'h33);
    check("flush_next_pop", pop_count, 28);
    m_ready = 1'b1;
    cyc(2);
    m_ready = 1'b0;
    check("flush_last", delivered[delivered.size() - 1], 8'h33);
    check("flush_drained", m_valid, 0);

    // Asynchronous reset while the buffer is full
    src.push_back(8'h44);
    src.push_back(8'h55);
    cyc(4);
    check("mid_full_valid", m_valid, 1);
    #1;
    rrst_n = 1'b0;
    rempty = 1'b1;
    src.delete();
    #1;
    check("async_valid", m_valid, 0);
    check("async_data", m_data, 8'h00);
    check("async_pop", pop_count, 0);
    check("async_pop_w", pop_count_w, 0);
    check("async_rinc", rinc, 0);
    cyc(2);
    rrst_n = 1'b1;
    cyc(2);
    check("after_reset_valid", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-domain output adapter for the dual-clock asynchronous FIFO. It sits directly downstream of the read-pointer/empty logic and the FIFO memory. It pulls words by driving `rinc` whenever `rempty` is low and buffer space exists, and presents them on a registered valid/ready stream (first-word-fall-through) to the read-side consumer. A 2-entry output buffer sustains one word per `rclk` with no combinational path from `m_ready` to `rinc`.

## Interface
- `DSIZE`, 8: data width.
- `CNTW`, 16: width of pop counter.
- `rclk`  in  1  read-domain clock; all logic on rising edge.
- `rrst_n`  in  1  reset, asynchronous, active-low; clock rclk.
- `rempty`  in  1  registered FIFO empty flag from read-pointer logic.
- `rdata`  in  DSIZE  FIFO memory read data, combinational from current `raddr`; valid whenever `rempty`=0.
- `rinc`  out  DSIZE-independent 1  pop request to read-pointer logic (combinational).
- `m_valid`  out  1  output word valid.
- `m_data`  out  DSIZE  output word (head of buffer).
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid` & `m_ready`.
- `flush`  in  1  synchronous discard of buffered words.
- `pop_count`  out  CNTW  number of FIFO pops since reset, wraps modulo 2^CNTW.

## Operation
- Buffer: two DSIZE registers, head `b0` and tail `b1`, plus occupancy `cnt` in 0..2; `m_valid` = (`cnt`!=0), `m_data` = `b0`.
- `rinc` = ~`rempty` & ~`flush` & (`cnt` < 2). It depends only on registered state, `rempty` and `flush`, never on `m_ready`.
- Pop: when `rinc`=1, `rdata` is captured at that edge. Accept: `m_valid` & `m_ready` at that edge.
- Per-edge update, evaluated together:
  - neither pop nor accept: hold.
  - pop only: write to slot `cnt` (`b0` if 0, `b1` if 1), `cnt`+1.
  - accept only: `b0`<=`b1`, `cnt`-1.
  - pop and accept with `cnt`=1: `b0`<=`rdata`, `cnt` stays 1.
  - pop and accept with `cnt`=0 cannot occur because `m_valid`=0.
- Ordering is strict FIFO: words leave `m_data` in pop order, with no duplication or loss except by flush.
- Flush: at an edge with `flush`=1, an accept in the same cycle still completes and counts as delivered. All remaining entries are discarded and `cnt`<=0. `rinc` is 0 for that cycle, so no pop occurs. FIFO contents are not touched.
- `pop_count` increments by 1 on every edge where `rinc`=1, wrapping from 2^CNTW-1 to 0.
- `b0`/`b1` contents are don't-care when not occupied. `m_data` must be stable while `m_valid` & ~`m_ready`.

## Timing
- Reset (async assert, sync release by upstream): `cnt`=0, `m_valid`=0, `m_data`=0, `b1`=0, `pop_count`=0. `rinc`=0 because `rempty` resets to 1.
- Latency: if `rempty` falls after edge N, `rinc`=1 during cycle N+1→ word captured at edge N+1, and `m_valid`=1 after edge N+1.
- Throughput: with FIFO non-empty and `m_ready` held 1, steady state is `cnt`=1 with one pop and one accept per cycle (100%).
- Backpressure: with `m_ready`=0, pops continue until `cnt`=2, then `rinc`=0. The first cycle with `m_ready`=1 frees a slot, and `rinc` reasserts in the following cycle. There is no throughput loss because `cnt` returns to 2 only if the consumer stalls again.
- FIFO drains while buffer holds data: `m_valid` stays 1 until the buffer empties. `rempty`=1 blocks `rinc` regardless of `cnt`.
- Reset mid-transfer: all buffered words are lost, and outputs return to their reset values immediately (asynchronously).

## Test plan
- Reset: assert `rrst_n`=0 with `rempty`=1 → `m_valid`=0, `m_data`=0, `pop_count`=0, `rinc`=0. On release with `rempty` still 1, all stay 0.
- Single word: `rempty` falls with `rdata`=0xA5 and `m_ready`=0 → `rinc`=1 for one cycle, `m_valid`=1 and `m_data`=0xA5 from the next edge, held stable for 5 stalled cycles, `pop_count`=1. The word is accepted when `m_ready`=1.
- Streaming: 16 words 0x00..0x0F available, `m_ready`=1 → one word per cycle in order 0x00..0x0F, `cnt` never exceeds 1, `pop_count`=16.
- Backpressure: 8 words available, `m_ready`=0 → exactly 2 pops, then `rinc`=0 with `cnt`=2. Toggling `m_ready` 1/0 randomly must deliver all 8 in order, with `pop_count`=8.
- Flush: `cnt`=2 holding 0x11, 0x22 with `flush`=1 and `m_ready`=1 in the same cycle → 0x11 delivered, 0x22 discarded, `m_valid`=0 next cycle, no pop that cycle. The next FIFO word appears afterward.
- Counter wrap: with `CNTW`=4, perform 17 pops → `pop_count` reads 1.
